// File: rtl/ir_sweep_seq.sv
// IR sensor sweep sequencer.
// Enables the IR emitters, waits for them to settle, then converts the eight
// sensor channels one after another through the shared A2D. The eight readings
// are collected in a working bank and copied to an output bank in a single
// cycle, so downstream logic always sees one coherent set of readings.
module ir_sweep_seq #(
    parameter int SETTLE_CYCLES = 4096,
    parameter int CNV_TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    output logic        IR_en,
    output logic [2:0]  chnnl,
    output logic        strt_cnv,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    input  logic [2:0]  sel,
    output logic [11:0] IR_dat,
    output logic        IR_vld,
    output logic        a2d_err,
    output logic        busy
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (CNV_TIMEOUT > 1) ? $clog2(CNV_TIMEOUT) : 1;
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(CNV_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CONV    = 3'd2,
        S_WAIT    = 3'd3,
        S_PUBLISH = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          err_q, err_d;
    logic [11:0]   work_q [8];
    logic [11:0]   work_d [8];
    logic [11:0]   bank_q [8];
    logic [11:0]   bank_d [8];

    // A channel is finished either by its done strobe or by running out of time.
    logic timed_out;
    logic chan_done;
    assign timed_out = (tmo_cnt_q == TIMEOUT_LAST);
    assign chan_done = cnv_cmplt || timed_out;

    // State, counters and both reading banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= '0;
                bank_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= work_d[i];
                bank_q[i] <= bank_d[i];
            end
        end
    end

    // Next-state selection; go is only looked at while idle, so it never queues.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (go) state_d = S_SETTLE;
            S_SETTLE:  if (settle_cnt_q == SETTLE_LAST) state_d = S_CONV;
            S_CONV:    state_d = S_WAIT;
            S_WAIT:    if (chan_done) state_d = (idx_q == 3'd7) ? S_PUBLISH : S_CONV;
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Counter, channel index, error flag and bank updates for each state.
    always_comb begin
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        idx_d        = idx_q;
        err_d        = err_q;
        work_d       = work_q;
        bank_d       = bank_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    settle_cnt_d = '0;
                    idx_d        = '0;
                    err_d        = 1'b0;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q != SETTLE_LAST) settle_cnt_d = settle_cnt_q + SW'(1);
            end
            S_CONV: begin
                tmo_cnt_d = '0;
            end
            S_WAIT: begin
                if (cnv_cmplt) begin
                    work_d[idx_q] = res;
                end else if (timed_out) begin
                    // A dead channel reads as zero so the set can still be published.
                    work_d[idx_q] = 12'h000;
                    err_d         = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
                if (chan_done && idx_q != 3'd7) idx_d = idx_q + 3'd1;
            end
            S_PUBLISH: begin
                bank_d = work_q;
            end
            default: ;
        endcase
    end

    // Moore outputs decoded from the registered state, plus the bank read port.
    always_comb begin
        IR_en    = (state_q != S_IDLE);
        busy     = (state_q != S_IDLE);
        strt_cnv = (state_q == S_CONV);
        IR_vld   = (state_q == S_PUBLISH);
        chnnl    = idx_q;
        a2d_err  = err_q;
        IR_dat   = bank_q[sel];
    end

endmodule

// File: tb/tb_ir_sweep_seq.sv
// Self-checking bench for ir_sweep_seq: randomized sweeps against a timing and
// reading model computed directly from the sequencing rules.
module tb_ir_sweep_seq;

    localparam int SETTLE = 8;
    localparam int CNV_TO = 16;
    localparam int A2D_LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        IR_en;
    logic [2:0]  chnnl;
    logic        strt_cnv;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [2:0]  sel;
    logic [11:0] IR_dat;
    logic        IR_vld;
    logic        a2d_err;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // A2D model state
    logic [11:0] res_tbl [8];
    int          supp_ch = -1;
    logic        inj = 1'b0;
    logic [4:0]  cv_pipe;
    logic [2:0]  ch_pipe [5];
    logic        mdl_cmplt;

    // Expected published bank and error flag
    logic [11:0] exp_out [8];
    bit          exp_err = 1'b0;

    // Observation records
    int strt_cyc[$];
    int strt_ch[$];
    int vld_cyc[$];
    int err_cyc = -1;

    ir_sweep_seq #(.SETTLE_CYCLES(SETTLE), .CNV_TIMEOUT(CNV_TO)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .IR_en(IR_en), .chnnl(chnnl),
        .strt_cnv(strt_cnv), .cnv_cmplt(cnv_cmplt), .res(res), .sel(sel),
        .IR_dat(IR_dat), .IR_vld(IR_vld), .a2d_err(a2d_err), .busy(busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A2D: done strobe and result arrive A2D_LAT cycles after the start pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_pipe <= '0;
        end else begin
            cv_pipe    <= {cv_pipe[3:0], strt_cnv};
            ch_pipe[0] <= chnnl;
            for (int i = 1; i < 5; i++) ch_pipe[i] <= ch_pipe[i-1];
        end
    end
    assign mdl_cmplt = cv_pipe[A2D_LAT-1] && (int'(ch_pipe[A2D_LAT-1]) != supp_ch);
    assign cnv_cmplt = mdl_cmplt | inj;
    assign res       = mdl_cmplt ? res_tbl[ch_pipe[A2D_LAT-1]] : 12'hABC;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Advance to the next falling edge and record what the DUT is doing.
    task automatic step();
        @(negedge clk);
        if (strt_cnv) begin
            strt_cyc.push_back(cyc);
            strt_ch.push_back(int'(chnnl));
        end
        if (IR_vld) vld_cyc.push_back(cyc);
        if (a2d_err && err_cyc < 0) err_cyc = cyc;
    endtask

    task automatic idle_gap(input int n, input bit inj_on);
        strt_cyc.delete();
        vld_cyc.delete();
        for (int k = 0; k < n; k++) begin
            step();
            inj = inj_on ? 1'($urandom_range(0, 1)) : 1'b0;
            sel = 3'($urandom_range(0, 7));
            #1;
            chk("idle_busy", 32'(busy), 32'(0));
            chk("idle_dat", 32'(IR_dat), 32'(exp_out[sel]));
            chk("idle_err", 32'(a2d_err), 32'(exp_err));
        end
        step();
        inj = 1'b0;
        chk("idle_no_strt", strt_cyc.size(), 0);
        chk("idle_no_vld", vld_cyc.size(), 0);
    endtask

    task automatic run_sweep(input int supp, input bit go2, input bit inj_settle);
        logic [11:0] nb [8];
        int exp_strt [8];
        int t;
        int g;
        int exp_vld;
        bit done;
        bit go2_pend;
        // Reference: readings, then start times from settle length, A2D latency and timeout.
        for (int i = 0; i < 8; i++) nb[i] = (i == supp) ? 12'h000 : res_tbl[i];
        supp_ch = supp;
        step();
        inj = 1'b0;
        g  = cyc;
        go = 1'b1;
        t  = g + 1 + SETTLE;
        for (int i = 0; i < 8; i++) begin
            exp_strt[i] = t;
            t += (i == supp) ? CNV_TO + 1 : A2D_LAT + 1;
        end
        exp_vld = t;
        strt_cyc.delete();
        strt_ch.delete();
        vld_cyc.delete();
        err_cyc  = -1;
        done     = 1'b0;
        go2_pend = 1'b0;
        for (int k = 1; k < 400 && !done; k++) begin
            step();
            go       = go2_pend;
            go2_pend = 1'b0;
            inj      = (inj_settle && k <= 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (go2 && strt_cnv && chnnl == 3'd3) go2_pend = 1'b1;
            if (k == 1) begin
                chk("ir_en_on", 32'(IR_en), 32'(1));
                chk("err_clr_on_go", 32'(a2d_err), 32'(0));
            end
            chk("busy_run", 32'(busy), 32'(1));
            sel = 3'($urandom_range(0, 7));
            #1;
            chk("dat_stable", 32'(IR_dat), 32'(exp_out[sel]));
            if (IR_vld) done = 1'b1;
        end
        go  = 1'b0;
        inj = 1'b0;
        chk("vld_seen", 32'(done), 32'(1));
        chk("vld_count", vld_cyc.size(), 1);
        if (vld_cyc.size() > 0) chk("vld_cycle", vld_cyc[0], exp_vld);
        chk("strt_count", strt_cyc.size(), 8);
        for (int i = 0; i < 8 && i < strt_cyc.size(); i++) begin
            chk("strt_ch", strt_ch[i], i);
            chk("strt_cycle", strt_cyc[i], exp_strt[i]);
        end
        exp_err = (supp >= 0);
        chk("a2d_err", 32'(a2d_err), 32'(exp_err));
        if (supp >= 0) chk("err_rise", err_cyc, exp_strt[supp] + CNV_TO + 1);
        step();
        chk("vld_single", 32'(IR_vld), 32'(0));
        chk("ir_en_off", 32'(IR_en), 32'(0));
        chk("busy_off", 32'(busy), 32'(0));
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            chk("dat_new", 32'(IR_dat), 32'(nb[s]));
        end
        for (int i = 0; i < 8; i++) exp_out[i] = nb[i];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        go    = 1'b0;
        sel   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            res_tbl[i] = 12'h000;
            exp_out[i] = 12'h000;
        end
        step();
        step();
        chk("rst_ir_en", 32'(IR_en), 32'(0));
        chk("rst_strt", 32'(strt_cnv), 32'(0));
        chk("rst_vld", 32'(IR_vld), 32'(0));
        chk("rst_err", 32'(a2d_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_chnnl", 32'(chnnl), 32'(0));
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            chk("rst_dat", 32'(IR_dat), 32'(0));
        end
        step();
        rst_n = 1'b1;

        // Idle after reset, with stray done strobes: nothing may start or change.
        idle_gap(10, 1'b1);

        // Basic sweep with the nominal A2D readings.
        for (int i = 0; i < 8; i++) res_tbl[i] = 12'(12'h100 * (i + 1));
        run_sweep(-1, 1'b0, 1'b1);
        idle_gap(4, 1'b1);

        // Extra go during channel 3 must not be queued.
        for (int i = 0; i < 8; i++) res_tbl[i] = 12'($urandom_range(0, 4095));
        run_sweep(-1, 1'b1, 1'b0);
        idle_gap(6, 1'b0);

        // Channel 5 never answers.
        run_sweep(5, 1'b0, 1'b0);
        idle_gap(3, 1'b1);

        // Next accepted go clears the error; readings swap to all-ones.
        for (int i = 0; i < 8; i++) res_tbl[i] = 12'hFFF;
        run_sweep(-1, 1'b0, 1'b0);
        idle_gap(3, 1'b0);

        // Reset during channel 4's conversion.
        for (int i = 0; i < 8; i++) res_tbl[i] = 12'(12'h100 * (i + 1));
        supp_ch = -1;
        step();
        go = 1'b1;
        strt_cyc.delete();
        vld_cyc.delete();
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            go = 1'b0;
            if (strt_cnv && chnnl == 3'd4) found = 1'b1;
        end
        chk("reach_ch4", 32'(found), 32'(1));
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ir_en", 32'(IR_en), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_strt", 32'(strt_cnv), 32'(0));
        chk("mid_rst_chnnl", 32'(chnnl), 32'(0));
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            chk("mid_rst_dat", 32'(IR_dat), 32'(0));
        end
        step();
        rst_n = 1'b1;
        chk("mid_rst_no_vld", vld_cyc.size(), 0);
        for (int i = 0; i < 8; i++) exp_out[i] = 12'h000;
        exp_err = 1'b0;
        idle_gap(12, 1'b1);
        run_sweep(-1, 1'b0, 1'b1);
        idle_gap(3, 1'b0);

        // Randomized sweeps.
        for (int r = 0; r < 6; r++) begin
            int supp;
            for (int i = 0; i < 8; i++) res_tbl[i] = 12'($urandom_range(0, 4095));
            supp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_sweep(supp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle_gap(int'($urandom_range(2, 8)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
